// File: rtl/uc_sequenciador_pkg.sv
// State encoding and helpers shared by the game-tick sequencer.
package uc_sequenciador_pkg;

    typedef enum logic [4:0] {
        INICIO    = 5'd0,
        SPAWN_INI = 5'd1,
        SPAWN_ESP = 5'd2,
        ESPERA    = 5'd3,
        FASE_INI  = 5'd4,
        FASE_ESP  = 5'd5,
        STEP_INI  = 5'd6,
        STEP_ESP  = 5'd7,
        FRAME_INI = 5'd8,
        FRAME_ESP = 5'd9,
        TX_INI    = 5'd10,
        TX_ESP    = 5'd11,
        FIM       = 5'd12,
        ERRO      = 5'd31
    } estado_t;

    // True for the states that wait on a sub-unit done (watchdog-guarded).
    function automatic logic eh_espera(estado_t e);
        case (e)
            SPAWN_ESP, FASE_ESP, STEP_ESP, FRAME_ESP, TX_ESP: eh_espera = 1'b1;
            default:                                          eh_espera = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uc_sequenciador_fases_watchdog.sv
// Per-wait watchdog: counts cycles spent in a wait state, flags the last one.
module contador_watchdog #(
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned W_TO    = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W_TO-1:0] LIMITE = W_TO'(TIMEOUT - 1);

    logic [W_TO-1:0] wd_cnt;

    // Counter restarts on every state change and saturates at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (clear)
            wd_cnt <= '0;
        else if (enable && (wd_cnt != LIMITE))
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign expired = enable && (wd_cnt == LIMITE);

endmodule

// File: rtl/uc_sequenciador_fases.sv
// Game-tick sequencer: spawn, N_FASES compare/move phases, frame, periodic tx.
module uc_sequenciador_fases
    import uc_sequenciador_pkg::*;
#(
    parameter int unsigned N_FASES = 2,
    parameter int unsigned W_FASE  = 1,
    parameter int unsigned TX_DIV  = 4,
    parameter int unsigned W_TX    = 3,
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned W_TO    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               spawn_req,
    input  logic               spawn_done,
    input  logic [N_FASES-1:0] fase_done,
    input  logic [N_FASES-1:0] fase_more,
    input  logic [N_FASES-1:0] step_done,
    input  logic               frame_done,
    input  logic               tx_done,
    input  logic               clear_erro,
    output logic               rng_reset,
    output logic               spawn_start,
    output logic [N_FASES-1:0] fase_start,
    output logic [N_FASES-1:0] step_start,
    output logic               frame_start,
    output logic               pause_render,
    output logic               tx_start,
    output logic               cycle_done,
    output logic               erro,
    output logic               overrun,
    output logic [W_FASE-1:0]  db_fase,
    output logic [4:0]         db_estado
);

    localparam logic [W_FASE-1:0] ULTIMA_FASE = W_FASE'(N_FASES - 1);
    localparam logic [W_TX-1:0]   ULTIMO_FRAME = W_TX'(TX_DIV - 1);

    estado_t           estado, proximo;
    logic [W_FASE-1:0] fase_idx, fase_idx_prox;
    logic [W_TX-1:0]   frame_cnt, frame_cnt_prox;
    logic              tick_pend, limpa_tick;
    logic              done_sel, more_sel, step_sel;
    logic              wd_exp;

    contador_watchdog #(
        .TIMEOUT (TIMEOUT),
        .W_TO    (W_TO)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (proximo != estado),
        .enable  (eh_espera(estado)),
        .expired (wd_exp)
    );

    // Pick the done/more/step bits of the active phase; other bits are ignored.
    always_comb begin
        done_sel = 1'b0;
        more_sel = 1'b0;
        step_sel = 1'b0;
        for (int unsigned i = 0; i < N_FASES; i++) begin
            if (fase_idx == W_FASE'(i)) begin
                done_sel = fase_done[i];
                more_sel = fase_more[i];
                step_sel = step_done[i];
            end
        end
    end

    // State, phase index and frame counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= INICIO;
            fase_idx  <= '0;
            frame_cnt <= '0;
        end else begin
            estado    <= proximo;
            fase_idx  <= fase_idx_prox;
            frame_cnt <= frame_cnt_prox;
        end
    end

    // Next-state logic; a done arriving with the watchdog expiry wins.
    always_comb begin
        proximo        = estado;
        fase_idx_prox  = fase_idx;
        frame_cnt_prox = frame_cnt;
        limpa_tick     = 1'b0;
        case (estado)
            INICIO:    proximo = SPAWN_INI;
            SPAWN_INI: proximo = SPAWN_ESP;
            SPAWN_ESP: begin
                if (spawn_done)  proximo = ESPERA;
                else if (wd_exp) proximo = ERRO;
            end
            ESPERA: begin
                if (spawn_req) begin
                    proximo = SPAWN_INI;
                end else if (tick_pend) begin
                    proximo       = FASE_INI;
                    fase_idx_prox = '0;
                    limpa_tick    = 1'b1;
                end
            end
            FASE_INI:  proximo = FASE_ESP;
            FASE_ESP: begin
                if (done_sel) begin
                    if (more_sel) begin
                        proximo = STEP_INI;
                    end else if (fase_idx == ULTIMA_FASE) begin
                        proximo = FRAME_INI;
                    end else begin
                        proximo       = FASE_INI;
                        fase_idx_prox = fase_idx + 1'b1;
                    end
                end else if (wd_exp) begin
                    proximo = ERRO;
                end
            end
            STEP_INI:  proximo = STEP_ESP;
            STEP_ESP: begin
                if (step_sel)    proximo = FASE_INI;
                else if (wd_exp) proximo = ERRO;
            end
            FRAME_INI: proximo = FRAME_ESP;
            FRAME_ESP: begin
                if (frame_done) begin
                    if (frame_cnt == ULTIMO_FRAME) begin
                        proximo        = TX_INI;
                        frame_cnt_prox = '0;
                    end else begin
                        proximo        = FIM;
                        frame_cnt_prox = frame_cnt + 1'b1;
                    end
                end else if (wd_exp) begin
                    proximo = ERRO;
                end
            end
            TX_INI:    proximo = TX_ESP;
            TX_ESP: begin
                if (tx_done)     proximo = FIM;
                else if (wd_exp) proximo = ERRO;
            end
            FIM:       proximo = ESPERA;
            ERRO: begin
                if (clear_erro) proximo = INICIO;
            end
            default:   proximo = INICIO;
        endcase
    end

    // Tick latch: a new tick beats the same-cycle consume; a tick on a pending one is an overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_pend <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (tick)            tick_pend <= 1'b1;
            else if (limpa_tick) tick_pend <= 1'b0;

            if ((estado == ERRO) && clear_erro)
                overrun <= 1'b0;
            else if (tick && tick_pend && !limpa_tick)
                overrun <= 1'b1;
        end
    end

    // Moore outputs decoded from the registered state and phase index.
    always_comb begin
        rng_reset    = (estado == INICIO);
        spawn_start  = (estado == SPAWN_INI);
        frame_start  = (estado == FRAME_INI);
        pause_render = (estado == FRAME_INI) || (estado == FRAME_ESP);
        tx_start     = (estado == TX_INI);
        cycle_done   = (estado == FIM);
        erro         = (estado == ERRO);
        db_fase      = fase_idx;
        db_estado    = estado;
        fase_start   = '0;
        step_start   = '0;
        for (int unsigned i = 0; i < N_FASES; i++) begin
            fase_start[i] = (estado == FASE_INI) && (fase_idx == W_FASE'(i));
            step_start[i] = (estado == STEP_INI) && (fase_idx == W_FASE'(i));
        end
    end

endmodule

// File: doc/uc_sequenciador_fases.md
Name: uc_sequenciador_fases

Overview:
Parametrised game-tick sequencer. Runs N_FASES compare/move phase pairs, then frame generation, then a periodic data transmission every TX_DIV frames. Asteroid spawn requests take priority between ticks. Adds tick latching with overrun detection, plus a per-wait watchdog that traps hung sub-units in an error state. Sits in the control path between the game-tick timer and the asteroid/shot/frame/serial datapath units.

Parameters:
N_FASES, 2, number of compare/move phase pairs (>=1); phase 0 runs first.
W_FASE, 1, width of phase index (>= clog2(N_FASES), min 1).
TX_DIV, 4, frames per transmission (>=1; 1 = every frame).
W_TX, 3, width of frame counter (holds TX_DIV-1).
TIMEOUT, 50000, max cycles in any wait state before error.
W_TO, 16, watchdog counter width (holds TIMEOUT-1).

Ports:
clock in 1 system clock
reset in 1 asynchronous, active-high
tick in 1 one-cycle request to run one game cycle
spawn_req in 1 level, request asteroid generation
spawn_done in 1 generator finished
fase_done in N_FASES compare-step finished, per phase
fase_more in N_FASES sampled with fase_done: 1 = run move step and repeat
step_done in N_FASES move-step finished, per phase
frame_done in 1 frame generator finished
tx_done in 1 serial transmitter finished
clear_erro in 1 leave ERRO
rng_reset out 1 high in INICIO
spawn_start out 1 pulse, SPAWN_INI
fase_start out N_FASES one-hot pulse, FASE_INI, bit = fase_idx
step_start out N_FASES one-hot pulse, STEP_INI, bit = fase_idx
frame_start out 1 pulse, FRAME_INI
pause_render out 1 high in FRAME_INI and FRAME_ESP
tx_start out 1 pulse, TX_INI
cycle_done out 1 pulse, FIM
erro out 1 high in ERRO
overrun out 1 sticky: tick arrived while tick_pend already set
db_fase out W_FASE current fase_idx
db_estado out 5 state code

Behaviour:
- Moore FSM. All outputs are decoded from registered state only. Reset (async) forces INICIO, fase_idx=0, frame_cnt=0, wd_cnt=0, tick_pend=0, overrun=0. All pulses are 0 at reset except rng_reset=1.
- State codes: INICIO 0, SPAWN_INI 1, SPAWN_ESP 2, ESPERA 3, FASE_INI 4, FASE_ESP 5, STEP_INI 6, STEP_ESP 7, FRAME_INI 8, FRAME_ESP 9, TX_INI 10, TX_ESP 11, FIM 12, ERRO 31. Unknown codes go to INICIO.
- Transitions:
  - INICIO->SPAWN_INI->SPAWN_ESP.
  - SPAWN_ESP: spawn_done -> ESPERA.
  - ESPERA: spawn_req -> SPAWN_INI (priority); else tick_pend -> FASE_INI with fase_idx=0, clear tick_pend; else stay.
  - FASE_INI->FASE_ESP.
  - FASE_ESP, on fase_done[idx]: if fase_more[idx] -> STEP_INI; else if idx==N_FASES-1 -> FRAME_INI; else idx+1 -> FASE_INI.
  - STEP_INI->STEP_ESP.
  - STEP_ESP: step_done[idx] -> FASE_INI (same idx).
  - FRAME_INI->FRAME_ESP.
  - FRAME_ESP, on frame_done: if frame_cnt==TX_DIV-1 then frame_cnt=0 -> TX_INI; else frame_cnt+1 -> FIM.
  - TX_INI->TX_ESP. TX_ESP: tx_done -> FIM.
  - FIM->ESPERA.
  - ERRO: clear_erro -> INICIO.
- done/step_done bits for indices other than fase_idx are ignored.
- Tick latch: tick sets tick_pend in any state. Set wins over the same-cycle clear in ESPERA; that tick is kept for the next cycle. tick while tick_pend=1 (not being cleared) sets overrun. overrun is cleared only by reset or by clear_erro in ERRO.
- Watchdog: wd_cnt is 0 on any state change and increments each cycle in *_ESP states. If it reaches TIMEOUT-1 with the awaited done still low, the next state is ERRO. A done on the same cycle wins over the timeout.
- In ERRO, all start pulses are 0 and db_fase holds the hung phase.
- Minimum latency tick->cycle_done (N_FASES=2, no moves, no tx, dones returned the cycle after entering each wait): 9 cycles after tick_pend is seen in ESPERA.

Decomposition:
- Package uc_sequenciador_pkg: state encoding constants and db_estado codes.
- One sub-module: contador_watchdog (clear, enable, TIMEOUT parameter, expired output).

Test Plan:
- Reset then spawn_done after 3 cycles -> rng_reset 1 cycle, spawn_start 1 cycle, ESPERA (db_estado=3).
- tick, fase_more=0 on both phases, TX_DIV=4 -> fase_start 01 then 10, frame_start, cycle_done. tx_start only on the 4th tick.
- Phase 0 returns fase_more=1 twice, then 0 -> step_start[0] pulses 2×, fase_start[0] pulses 3×, then phase 1.
- spawn_req and tick asserted together in ESPERA -> spawn runs first, then game cycle without new tick. Two extra ticks during the cycle -> overrun=1.
- Withhold frame_done, TIMEOUT=20 -> ERRO (db_estado=31, erro=1) 20 cycles after FRAME_ESP entry. clear_erro -> INICIO.
- Assert reset during STEP_ESP -> INICIO immediately; fase_idx, frame_cnt, overrun all 0.
